// File: rtl/network_mul_arbiter.sv
// Round-robin front end for one shared pipelined 16s x 11u multiplier.
// NREQ requesters compete for the multiplier. A {valid, tag} shift register
// runs alongside the external multiplier pipeline and labels each product
// with the requester that issued it. The whole pipeline freezes while a
// result is held and the consumer is not ready.
module network_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [16*NREQ-1:0]    req_din0,
  input  logic [11*NREQ-1:0]    req_din1,
  output logic [NREQ-1:0]       req_ready,
  output logic                  mul_ce,
  output logic [15:0]           mul_din0,
  output logic [10:0]           mul_din1,
  input  logic [26:0]           mul_dout,
  output logic                  res_valid,
  output logic [TAG_W-1:0]      res_tag,
  output logic [26:0]           res_data,
  input  logic                  res_ready
);

  logic                  advance;
  logic                  any_valid;
  logic                  transfer;
  logic [NREQ-1:0]       hi_mask;
  logic [NREQ-1:0]       hi_req;
  logic [TAG_W-1:0]      grant;
  logic [TAG_W-1:0]      rr_ptr_reg;
  logic [MUL_LAT-1:0]    stage_valid_reg;
  logic [TAG_W-1:0]      stage_tag_reg [MUL_LAT];

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [TAG_W-1:0] lowest_set(input logic [NREQ-1:0] v);
    logic [TAG_W-1:0] r;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) r = TAG_W'(i);
    end
    return r;
  endfunction

  // A held result that nobody takes stops everything; otherwise bubbles drain.
  assign advance   = ~res_valid | res_ready;
  assign mul_ce    = advance;
  assign any_valid = |req_valid;
  assign transfer  = advance & any_valid;

  // Requesters at or above the round-robin pointer get first pick.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign hi_mask[gi] = (rr_ptr_reg <= TAG_W'(gi));
    end
  endgenerate

  assign hi_req = req_valid & hi_mask;

  // Search upward from the pointer, wrapping to index 0 when nothing is found.
  always_comb begin
    if (|hi_req) grant = lowest_set(hi_req);
    else         grant = lowest_set(req_valid);
  end

  // Route the granted requester's operands to the multiplier and ack it.
  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (any_valid && (grant == TAG_W'(i))) begin
        mul_din0     = req_din0[16*i +: 16];
        mul_din1     = req_din1[11*i +: 11];
        req_ready[i] = advance;
      end
    end
  end

  // Pointer moves just past the winner on every accepted transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
    end else if (transfer) begin
      rr_ptr_reg <= (grant == TAG_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  // First tag stage captures this cycle's transfer alongside the operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_reg[0] <= 1'b0;
      stage_tag_reg[0]   <= '0;
    end else if (advance) begin
      stage_valid_reg[0] <= transfer;
      stage_tag_reg[0]   <= grant;
    end
  end

  // Remaining tag stages shift in lockstep with the multiplier pipeline.
  generate
    for (gi = 1; gi < MUL_LAT; gi++) begin : g_stage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stage_valid_reg[gi] <= 1'b0;
          stage_tag_reg[gi]   <= '0;
        end else if (advance) begin
          stage_valid_reg[gi] <= stage_valid_reg[gi-1];
          stage_tag_reg[gi]   <= stage_tag_reg[gi-1];
        end
      end
    end
  endgenerate

  assign res_valid = stage_valid_reg[MUL_LAT-1];
  assign res_tag   = stage_tag_reg[MUL_LAT-1];
  assign res_data  = mul_dout;

endmodule
